// File: rtl/id_stage_pipelined.sv
// LEGv8 decode stage: register read with write-back bypass, immediate extension,
// main control, load-use stall and branch flush, registered into ID/EX.
module id_stage_pipelined #(
  parameter int WORD      = 64,
  parameter int INSTR_LEN = 32,
  parameter int NUM_REGS  = 32,
  parameter int RADDR_W   = 5,
  parameter int XZR_EN    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_valid,
  input  logic [INSTR_LEN-1:0] instr,
  input  logic                 flush,
  input  logic                 wb_en,
  input  logic [RADDR_W-1:0]   wb_addr,
  input  logic [WORD-1:0]      wb_data,
  output logic                 stall_out,
  output logic                 ex_valid,
  output logic [WORD-1:0]      ex_read_data1,
  output logic [WORD-1:0]      ex_read_data2,
  output logic [WORD-1:0]      ex_ext_addr,
  output logic [10:0]          ex_alu_con_instr,
  output logic [RADDR_W-1:0]   ex_rn,
  output logic [RADDR_W-1:0]   ex_rm,
  output logic [RADDR_W-1:0]   ex_rd,
  output logic                 ex_uncondbranch,
  output logic                 ex_branch,
  output logic                 ex_mem_read,
  output logic                 ex_mem_to_reg,
  output logic                 ex_mem_write,
  output logic                 ex_alu_src,
  output logic                 ex_reg_write,
  output logic [1:0]           ex_alu_op
);

  localparam logic [RADDR_W-1:0] XZR_ADDR = RADDR_W'(NUM_REGS - 1);

  logic [WORD-1:0] regs [NUM_REGS];

  logic [10:0]        opcode;
  logic               is_ldur, is_stur, is_rtype, is_cbz, is_b;
  logic               uses_rs2;
  logic [RADDR_W-1:0] rn, rs2, rd;
  logic               rn_xzr, rs2_xzr, wb_xzr, ex_rd_xzr;
  logic [WORD-1:0]    rdata1, rdata2, imm;

  logic dec_uncondbranch, dec_branch, dec_mem_read, dec_mem_to_reg;
  logic dec_mem_write, dec_alu_src, dec_reg_write;
  logic [1:0] dec_alu_op;

  assign opcode   = instr[31:21];
  assign is_ldur  = (opcode == 11'h7C2);
  assign is_stur  = (opcode == 11'h7C0);
  assign is_rtype = (opcode == 11'h458) || (opcode == 11'h658) ||
                    (opcode == 11'h450) || (opcode == 11'h550);
  assign is_cbz   = (instr[31:24] == 8'hB4);
  assign is_b     = (instr[31:26] == 6'h05);
  assign uses_rs2 = is_rtype || is_stur || is_cbz;

  // STUR and CBZ read Rt through the second port so EX sees the store/test value.
  assign rn  = instr[5 +: RADDR_W];
  assign rd  = instr[0 +: RADDR_W];
  assign rs2 = (is_stur || is_cbz) ? instr[0 +: RADDR_W] : instr[16 +: RADDR_W];

  assign rn_xzr    = (XZR_EN != 0) && (rn == XZR_ADDR);
  assign rs2_xzr   = (XZR_EN != 0) && (rs2 == XZR_ADDR);
  assign wb_xzr    = (XZR_EN != 0) && (wb_addr == XZR_ADDR);
  assign ex_rd_xzr = (XZR_EN != 0) && (ex_rd == XZR_ADDR);

  always_ff @(posedge clk) begin
    if (wb_en && !wb_xzr) regs[wb_addr] <= wb_data;
  end

  always_comb begin
    rdata1 = regs[rn];
    if (rn_xzr) rdata1 = '0;
    else if (wb_en && wb_addr == rn) rdata1 = wb_data;
    rdata2 = regs[rs2];
    if (rs2_xzr) rdata2 = '0;
    else if (wb_en && wb_addr == rs2) rdata2 = wb_data;
  end

  always_comb begin
    dec_uncondbranch = 1'b0;
    dec_branch       = 1'b0;
    dec_mem_read     = 1'b0;
    dec_mem_to_reg   = 1'b0;
    dec_mem_write    = 1'b0;
    dec_alu_src      = 1'b0;
    dec_reg_write    = 1'b0;
    dec_alu_op       = 2'b00;
    imm              = '0;
    if (is_ldur) begin
      dec_mem_read   = 1'b1;
      dec_mem_to_reg = 1'b1;
      dec_alu_src    = 1'b1;
      dec_reg_write  = 1'b1;
      imm            = {{(WORD-9){instr[20]}}, instr[20:12]};
    end else if (is_stur) begin
      dec_mem_write  = 1'b1;
      dec_alu_src    = 1'b1;
      imm            = {{(WORD-9){instr[20]}}, instr[20:12]};
    end else if (is_rtype) begin
      dec_reg_write  = 1'b1;
      dec_alu_op     = 2'b10;
    end else if (is_cbz) begin
      dec_branch     = 1'b1;
      dec_alu_op     = 2'b01;
      imm            = {{(WORD-19){instr[23]}}, instr[23:5]};
    end else if (is_b) begin
      dec_uncondbranch = 1'b1;
      imm              = {{(WORD-26){instr[25]}}, instr[25:0]};
    end
  end

  // Load-use: the load in ID/EX has not produced its data yet, so hold and retry.
  assign stall_out = id_valid && ex_valid && ex_mem_read && !ex_rd_xzr &&
                     ((ex_rd == rn) || (uses_rs2 && ex_rd == rs2));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid         <= 1'b0;
      ex_read_data1    <= '0;
      ex_read_data2    <= '0;
      ex_ext_addr      <= '0;
      ex_alu_con_instr <= '0;
      ex_rn            <= '0;
      ex_rm            <= '0;
      ex_rd            <= '0;
      ex_uncondbranch  <= 1'b0;
      ex_branch        <= 1'b0;
      ex_mem_read      <= 1'b0;
      ex_mem_to_reg    <= 1'b0;
      ex_mem_write     <= 1'b0;
      ex_alu_src       <= 1'b0;
      ex_reg_write     <= 1'b0;
      ex_alu_op        <= 2'b00;
    end else begin
      ex_read_data1    <= rdata1;
      ex_read_data2    <= rdata2;
      ex_ext_addr      <= imm;
      ex_alu_con_instr <= opcode;
      ex_rn            <= rn;
      ex_rm            <= rs2;
      ex_rd            <= rd;
      if (flush || stall_out || !id_valid) begin
        ex_valid         <= 1'b0;
        ex_uncondbranch  <= 1'b0;
        ex_branch        <= 1'b0;
        ex_mem_read      <= 1'b0;
        ex_mem_to_reg    <= 1'b0;
        ex_mem_write     <= 1'b0;
        ex_alu_src       <= 1'b0;
        ex_reg_write     <= 1'b0;
        ex_alu_op        <= 2'b00;
      end else begin
        ex_valid         <= 1'b1;
        ex_uncondbranch  <= dec_uncondbranch;
        ex_branch        <= dec_branch;
        ex_mem_read      <= dec_mem_read;
        ex_mem_to_reg    <= dec_mem_to_reg;
        ex_mem_write     <= dec_mem_write;
        ex_alu_src       <= dec_alu_src;
        ex_reg_write     <= dec_reg_write;
        ex_alu_op        <= dec_alu_op;
      end
    end
  end

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Bench for id_stage_pipelined: directed scenarios plus a randomized run against
// an instruction-level reference model of decode, register file and hazards.
module tb_id_stage_pipelined;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] instr;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [63:0] wb_data;
  logic        stall_out;
  logic        ex_valid;
  logic [63:0] ex_read_data1, ex_read_data2, ex_ext_addr;
  logic [10:0] ex_alu_con_instr;
  logic [4:0]  ex_rn, ex_rm, ex_rd;
  logic        ex_uncondbranch, ex_branch, ex_mem_read, ex_mem_to_reg;
  logic        ex_mem_write, ex_alu_src, ex_reg_write;
  logic [1:0]  ex_alu_op;

  int n_checks = 0;
  int n_errors = 0;

  id_stage_pipelined dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .instr(instr), .flush(flush),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .stall_out(stall_out),
    .ex_valid(ex_valid), .ex_read_data1(ex_read_data1), .ex_read_data2(ex_read_data2),
    .ex_ext_addr(ex_ext_addr), .ex_alu_con_instr(ex_alu_con_instr),
    .ex_rn(ex_rn), .ex_rm(ex_rm), .ex_rd(ex_rd),
    .ex_uncondbranch(ex_uncondbranch), .ex_branch(ex_branch),
    .ex_mem_read(ex_mem_read), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src),
    .ex_reg_write(ex_reg_write), .ex_alu_op(ex_alu_op)
  );

  always #5 clk = ~clk;

  // ctl order: uncond, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, alu_op[1:0]
  typedef struct packed {
    logic        valid;
    logic [8:0]  ctl;
    logic        uses2;
    logic [63:0] rd1, rd2, imm;
    logic [10:0] alu;
    logic [4:0]  rn, rm, rd;
  } ent_t;

  logic [63:0] mem [32];
  ent_t m_cur, m_next;
  logic m_stall;

  function automatic logic [8:0] obs_ctl();
    return {ex_uncondbranch, ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write,
            ex_alu_src, ex_reg_write, ex_alu_op};
  endfunction

  function automatic logic [63:0] model_read(input logic [4:0] a);
    if (a == 5'd31) return 64'd0;
    if (wb_en && wb_addr == a) return wb_data;
    return mem[a];
  endfunction

  function automatic ent_t model_decode(input logic [31:0] ins);
    ent_t e;
    logic [10:0] op;
    op = ins[31:21];
    e = '0;
    e.alu = op;
    e.rn = ins[9:5];
    e.rd = ins[4:0];
    e.rm = ins[20:16];
    if (op == 11'h7C2) begin
      e.ctl = 9'b001101100;
      e.imm = 64'($signed(ins[20:12]));
    end else if (op == 11'h7C0) begin
      e.ctl = 9'b000011000; e.uses2 = 1'b1; e.rm = ins[4:0];
      e.imm = 64'($signed(ins[20:12]));
    end else if (op == 11'h458 || op == 11'h658 || op == 11'h450 || op == 11'h550) begin
      e.ctl = 9'b000000110; e.uses2 = 1'b1;
    end else if (ins[31:24] == 8'hB4) begin
      e.ctl = 9'b010000001; e.uses2 = 1'b1; e.rm = ins[4:0];
      e.imm = 64'($signed(ins[23:5]));
    end else if (ins[31:26] == 6'h05) begin
      e.ctl = 9'b100000000;
      e.imm = 64'($signed(ins[25:0]));
    end
    e.rd1 = model_read(e.rn);
    e.rd2 = model_read(e.rm);
    return e;
  endfunction

  task automatic drive(input logic v, input logic [31:0] ins, input logic fl,
                       input logic we, input logic [4:0] wa, input logic [63:0] wd);
    ent_t d;
    id_valid = v; instr = ins; flush = fl; wb_en = we; wb_addr = wa; wb_data = wd;
    d = model_decode(ins);
    m_stall = v && m_cur.valid && m_cur.ctl[6] && (m_cur.rd != 5'd31) &&
              ((m_cur.rd == d.rn) || (d.uses2 && m_cur.rd == d.rm));
    m_next = d;
    m_next.valid = v && !fl && !m_stall;
    if (!m_next.valid) m_next.ctl = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    m_cur = m_next;
    if (wb_en && wb_addr != 5'd31) mem[wb_addr] = wb_data;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 64'd0);
    m_cur = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({ex_valid, obs_ctl()} !== 10'd0) begin
      n_errors++; $display("FAIL reset_ctl: got %b want 0", {ex_valid, obs_ctl()});
    end
    n_checks++;
    if ({ex_read_data1, ex_read_data2, ex_ext_addr, ex_alu_con_instr, ex_rn, ex_rm, ex_rd} !== '0) begin
      n_errors++; $display("FAIL reset_data: got nonzero data fields, want 0");
    end
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b1, 5'(i), {$urandom, $urandom});
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 64'd0);
    tick();
  endtask

  task automatic test_ldur();
    drive(1'b1, 32'hF84402C9, 1'b0, 1'b0, 5'd0, 64'd0);
    tick();
    n_checks++;
    if ({ex_valid, obs_ctl()} !== {1'b1, 9'b001101100}) begin
      n_errors++; $display("FAIL ldur_ctl: got %b want 1001101100", {ex_valid, obs_ctl()});
    end
    n_checks++;
    if ({ex_ext_addr, ex_rn, ex_rd} !== {64'h40, 5'd22, 5'd9}) begin
      n_errors++; $display("FAIL ldur_fields: got imm=%h rn=%0d rd=%0d want 40/22/9",
                           ex_ext_addr, ex_rn, ex_rd);
    end
  endtask

  task automatic test_load_use();
    drive(1'b1, 32'hF84402C9, 1'b0, 1'b0, 5'd0, 64'd0);
    tick();
    drive(1'b1, 32'h8B0902A9, 1'b0, 1'b0, 5'd0, 64'd0);
    @(negedge clk);
    n_checks++;
    if (stall_out !== 1'b1) begin
      n_errors++; $display("FAIL loaduse_stall: got %b want 1", stall_out);
    end
    tick();
    n_checks++;
    if ({ex_valid, obs_ctl()} !== 10'd0) begin
      n_errors++; $display("FAIL loaduse_bubble: got %b want 0", {ex_valid, obs_ctl()});
    end
    drive(1'b1, 32'h8B0902A9, 1'b0, 1'b0, 5'd0, 64'd0);
    @(negedge clk);
    n_checks++;
    if (stall_out !== 1'b0) begin
      n_errors++; $display("FAIL loaduse_one_cycle: stall got %b want 0", stall_out);
    end
    tick();
    n_checks++;
    if ({ex_valid, ex_alu_con_instr, ex_alu_op} !== {1'b1, 11'h458, 2'b10}) begin
      n_errors++; $display("FAIL loaduse_issue: got v=%b alu=%h op=%b want 1/458/10",
                           ex_valid, ex_alu_con_instr, ex_alu_op);
    end
  endtask

  task automatic test_bypass();
    drive(1'b1, 32'h8B0902A9, 1'b0, 1'b1, 5'd21, 64'd10);
    tick();
    n_checks++;
    if (ex_read_data1 !== 64'd10) begin
      n_errors++; $display("FAIL bypass_rd1: got %0d want 10", ex_read_data1);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b1, 5'd31, 64'd20);
    tick();
    drive(1'b1, 32'h8B0903E9, 1'b0, 1'b1, 5'd31, 64'd20);
    tick();
    n_checks++;
    if (ex_read_data1 !== 64'd0) begin
      n_errors++; $display("FAIL xzr_read: got %0d want 0", ex_read_data1);
    end
  endtask

  task automatic test_branch();
    drive(1'b1, 32'hB4FFFF6B, 1'b0, 1'b0, 5'd0, 64'd0);
    tick();
    n_checks++;
    if ({ex_branch, ex_alu_op, ex_ext_addr, ex_rm} !== {1'b1, 2'b01, 64'hFFFF_FFFF_FFFF_FFFB, 5'd11}) begin
      n_errors++; $display("FAIL cbz: got br=%b op=%b imm=%h rm=%0d want 1/01/..FFFB/11",
                           ex_branch, ex_alu_op, ex_ext_addr, ex_rm);
    end
    drive(1'b1, 32'h17FFFFC9, 1'b0, 1'b0, 5'd0, 64'd0);
    tick();
    n_checks++;
    if ({ex_uncondbranch, ex_ext_addr} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFC9}) begin
      n_errors++; $display("FAIL b_neg: got ub=%b imm=%h want 1/..FFC9", ex_uncondbranch, ex_ext_addr);
    end
    drive(1'b1, 32'h14000040, 1'b0, 1'b0, 5'd0, 64'd0);
    tick();
    n_checks++;
    if (ex_ext_addr !== 64'h40) begin
      n_errors++; $display("FAIL b_pos: got imm=%h want 40", ex_ext_addr);
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 32'hF84402C9, 1'b0, 1'b0, 5'd0, 64'd0);
    tick();
    drive(1'b1, 32'h8B0902A9, 1'b1, 1'b0, 5'd0, 64'd0);
    tick();
    n_checks++;
    if ({ex_valid, obs_ctl()} !== 10'd0) begin
      n_errors++; $display("FAIL flush_bubble: got %b want 0", {ex_valid, obs_ctl()});
    end
    drive(1'b1, 32'h8B0902A9, 1'b0, 1'b0, 5'd0, 64'd0);
    tick();
    n_checks++;
    if ({ex_valid, ex_reg_write} !== 2'b11) begin
      n_errors++; $display("FAIL flush_after: got v=%b rw=%b want 1/1", ex_valid, ex_reg_write);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 32'hF84402C9, 1'b0, 1'b0, 5'd0, 64'd0);
    tick();
    #2 reset = 1'b1;
    #1;
    m_cur = '0;
    n_checks++;
    if ({ex_valid, obs_ctl(), ex_read_data1, ex_read_data2, ex_ext_addr, ex_alu_con_instr,
         ex_rn, ex_rm, ex_rd} !== '0) begin
      n_errors++; $display("FAIL reset_async: outputs not cleared, v=%b ctl=%b imm=%h",
                           ex_valid, obs_ctl(), ex_ext_addr);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    drive(1'b1, 32'h8B0902A9, 1'b0, 1'b0, 5'd0, 64'd0);
    @(negedge clk);
    n_checks++;
    if (stall_out !== 1'b0) begin
      n_errors++; $display("FAIL reset_nostall: got %b want 0", stall_out);
    end
    tick();
    n_checks++;
    if ({ex_valid, ex_alu_con_instr} !== {1'b1, 11'h458}) begin
      n_errors++; $display("FAIL reset_first_edge: got v=%b alu=%h want 1/458", ex_valid, ex_alu_con_instr);
    end
  endtask

  task automatic test_unknown();
    drive(1'b1, 32'h8A0A02CB, 1'b0, 1'b0, 5'd0, 64'd0);
    tick();
    n_checks++;
    if ({ex_valid, obs_ctl()} !== {1'b1, 9'b000000110}) begin
      n_errors++; $display("FAIL and_decode: got %b want 1000000110", {ex_valid, obs_ctl()});
    end
    drive(1'b1, 32'h0000_1234, 1'b0, 1'b0, 5'd0, 64'd0);
    tick();
    n_checks++;
    if ({ex_valid, obs_ctl(), ex_ext_addr} !== {1'b1, 9'd0, 64'd0}) begin
      n_errors++; $display("FAIL undef_decode: got v=%b ctl=%b imm=%h want 1/0/0",
                           ex_valid, obs_ctl(), ex_ext_addr);
    end
    drive(1'b0, 32'hF84402C9, 1'b0, 1'b0, 5'd0, 64'd0);
    tick();
    n_checks++;
    if ({ex_valid, obs_ctl()} !== 10'd0) begin
      n_errors++; $display("FAIL invalid_ctl: got %b want 0", {ex_valid, obs_ctl()});
    end
  endtask

  function automatic logic [4:0] pick_reg();
    int r;
    r = $urandom_range(0, 4);
    return (r == 4) ? 5'd31 : 5'(r);
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [10:0] rops [4];
    rops[0] = 11'h458; rops[1] = 11'h658; rops[2] = 11'h450; rops[3] = 11'h550;
    case ($urandom_range(0, 6))
      0, 6: return {11'h7C2, 9'($urandom), 2'b00, pick_reg(), pick_reg()};
      1:    return {11'h7C0, 9'($urandom), 2'b00, pick_reg(), pick_reg()};
      2:    return {rops[$urandom_range(0, 3)], pick_reg(), 6'($urandom), pick_reg(), pick_reg()};
      3:    return {8'hB4, 19'($urandom), pick_reg()};
      4:    return {6'h05, 26'($urandom)};
      default: return {11'h000, 21'($urandom)};
    endcase
  endfunction

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 7) != 0), gen_instr(), ($urandom_range(0, 9) == 0),
            1'($urandom), pick_reg(), {$urandom, $urandom});
      @(negedge clk);
      n_checks++;
      if (stall_out !== m_stall) begin
        n_errors++; $display("FAIL rand_stall[%0d]: got %b want %b instr=%h", i, stall_out, m_stall, instr);
      end
      tick();
      n_checks++;
      if ({ex_valid, obs_ctl()} !== {m_cur.valid, m_cur.ctl}) begin
        n_errors++; $display("FAIL rand_ctl[%0d]: got %b want %b", i, {ex_valid, obs_ctl()},
                             {m_cur.valid, m_cur.ctl});
      end
      if (m_cur.valid) begin
        n_checks++;
        if ({ex_read_data1, ex_read_data2, ex_ext_addr, ex_alu_con_instr, ex_rn, ex_rm, ex_rd} !==
            {m_cur.rd1, m_cur.rd2, m_cur.imm, m_cur.alu, m_cur.rn, m_cur.rm, m_cur.rd}) begin
          n_errors++; $display("FAIL rand_data[%0d]: got rd1=%h rd2=%h imm=%h want rd1=%h rd2=%h imm=%h",
                               i, ex_read_data1, ex_read_data2, ex_ext_addr, m_cur.rd1, m_cur.rd2, m_cur.imm);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_ldur();
    test_load_use();
    test_bypass();
    test_branch();
    test_flush();
    test_reset_mid();
    test_unknown();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/id_stage_pipelined.md
Name: id_stage_pipelined

Overview:
Parametrised successor to the single-cycle decode stage. Decodes one LEGv8 instruction per cycle and reads the register file with write-back bypass. Sign-extends the immediate and generates main control. Registers all results into an ID/EX pipeline register with a valid bit. Adds load-use hazard detection (stall plus bubble insertion) and a branch flush, which the unpipelined decoder lacks. Sits between the IF/ID register and the execute stage.

Parameters:
WORD, 64, datapath/register width in bits
INSTR_LEN, 32, instruction width
NUM_REGS, 32, architectural register count (power of two)
RADDR_W, 5, register address width, log2(NUM_REGS)
XZR_EN, 1, 1 = register NUM_REGS-1 reads 0 and ignores writes

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
id_valid  in  1  instr holds a valid instruction
instr  in  INSTR_LEN  instruction from IF/ID
flush  in  1  squash the instruction entering ID/EX (taken branch)
wb_en  in  1  write-back enable
wb_addr  in  RADDR_W  write-back register
wb_data  in  WORD  write-back data
stall_out  out  1  combinational; hold PC and IF/ID this cycle
ex_valid  out  1  ID/EX entry valid
ex_read_data1  out  WORD  R[Rn]
ex_read_data2  out  WORD  R[Rm], or R[Rt] for STUR/CBZ
ex_ext_addr  out  WORD  sign-extended immediate
ex_alu_con_instr  out  11  instr[31:21] for ALU control
ex_rn, ex_rm, ex_rd  out  RADDR_W each  register fields for forwarding
ex_uncondbranch, ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write  out  1 each  control
ex_alu_op  out  2  00 load/store, 01 CBZ, 10 R-type

Behaviour:
- Fields:
  - Rn = instr[9:5]; Rd/Rt = instr[4:0].
  - Second read address is instr[4:0] for STUR/CBZ, otherwise instr[20:16].
- Decode:
  - LDUR 11'h7C2: mem_read, mem_to_reg, alu_src, reg_write; alu_op=00.
  - STUR 11'h7C0: mem_write, alu_src; alu_op=00.
  - R-type ADD 458, SUB 658, AND 450, ORR 550: reg_write; alu_op=10.
  - CBZ instr[31:24]=8'hB4: branch; alu_op=01.
  - B instr[31:26]=6'h05: uncondbranch.
  - Any other opcode: all controls 0, but ex_valid still follows id_valid.
- Immediate sign extension to WORD:
  - D-format: instr[20:12].
  - CB: instr[23:5].
  - B: instr[25:0].
  - Otherwise 0.
- Register file: NUM_REGS x WORD.
  - Writes at the rising edge when wb_en=1.
  - With XZR_EN, writes to NUM_REGS-1 are discarded and reads of it return 0.
  - Reads are combinational with bypass: if wb_en and wb_addr equals a read address (not XZR), wb_data is returned the same cycle.
  - Register contents are not reset.
- Hazard: stall_out=1 when all of the following hold:
  - id_valid=1, ex_valid=1, ex_mem_read=1;
  - ex_rd is not XZR;
  - ex_rd equals Rn, or equals the second read address when the current instruction uses it (R-type, STUR, CBZ).
  - B and LDUR do not use the second read address.
- ID/EX register, updated each rising edge, priority reset > flush > stall > normal:
  - reset (async): ex_valid and all ex_ control outputs = 0; data, immediate and register-field outputs = 0.
  - flush=1: bubble loaded (ex_valid=0, all controls 0); stall_out is ignored that cycle.
  - stall_out=1: bubble loaded; the instruction is held by upstream and re-decoded next cycle, so the second attempt reads the forwarded or bypassed value.
  - normal: all decoded values loaded; ex_valid=id_valid. If id_valid=0, controls are forced to 0.
- Latency: one cycle from instr to ex_* outputs.
- Reset deasserting mid-stream: first post-reset edge behaves as normal.
- Stall never exceeds one consecutive cycle, because the bubble clears ex_mem_read.

Test Plan:
- Reset, then LDUR F84402C9 -> next cycle ex_mem_read=1, ex_alu_src=1, ex_reg_write=1, ex_alu_op=00, ex_ext_addr=0x40, ex_rn=22, ex_rd=9.
- LDUR F84402C9 followed by ADD 8B0902A9 -> stall_out=1 for one cycle, bubble (ex_valid=0) in ID/EX, then ADD issues with ex_alu_con_instr=11'h458 and ex_alu_op=10.
- Bypass: wb_en=1, wb_addr=21, wb_data=10 in the same cycle ADD 8B0902A9 decodes -> ex_read_data1=10 next cycle. wb_addr=31, wb_data=20, then read X31 -> 0.
- CBZ B4FFFF6B -> ex_branch=1, ex_alu_op=01, ex_ext_addr=64'hFFFF_FFFF_FFFF_FFFB, second read address=11. B 17FFFFC9 -> ex_uncondbranch=1, ex_ext_addr=64'hFFFF_FFFF_FFFF_FFC9. B 14000040 -> ex_ext_addr=0x40.
- flush=1 together with a stall condition -> bubble, stall_out ignored, ex_valid=0. Asserting reset mid-stream -> all ex_* outputs 0 immediately, without a clock edge.
- Unknown opcode 8A0A02CB (AND-class, 11'h450) -> ex_reg_write=1, ex_alu_op=10. A truly undefined opcode -> all controls 0 with ex_valid=1.
